// File: rtl/iob_native_rr_arbiter_pkg.sv
// Shared definitions for the native-bus round-robin arbiter.
// Holds the FSM state encoding, the default bus widths and the grant-width helper.
package iob_native_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // A single master still needs a one-bit grant index.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_native_rr_arbiter_rr_priority_select.sv
// Combinational round-robin winner search: rotates the request vector so that
// the master after 'last' sits at bit 0, takes the lowest set bit, then un-rotates.
module iob_native_rr_arbiter_rr_priority_select
    import iob_native_rr_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = grant_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] winner,
    output logic          found
);

    int         start_idx;
    int         pos;
    logic [N-1:0] rotated;

    // 'last' is always a valid master index, so the modulo keeps everything in 0..N-1.
    always_comb begin
        start_idx = (int'(last) + 1) % N;
        rotated   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == (start_idx + i) % N) begin
                    rotated[i] = req[j];
                end
            end
        end
        pos   = 0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pos   = i;
                found = 1'b1;
            end
        end
        winner = GW'((start_idx + pos) % N);
    end

endmodule

// File: rtl/iob_native_rr_arbiter.sv
// Round-robin arbiter sharing one native-bus slave among N_MASTERS requesters.
// A grant is taken in IDLE and held until the slave's ready pulse or an abort.
module iob_native_rr_arbiter
    import iob_native_rr_arbiter_pkg::*;
#(
    parameter int  N_MASTERS = 2,
    parameter int  ADDR_W    = DEFAULT_ADDR_W,
    parameter int  DATA_W    = DEFAULT_DATA_W,
    localparam int GW        = grant_width(N_MASTERS),
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [GW-1:0]                 grant,
    output logic                          busy
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [GW-1:0]        last_q;
    logic [GW-1:0]        winner;
    logic                 win_valid;
    logic                 owner_valid;
    logic [N_MASTERS-1:0] owner_onehot;

    iob_native_rr_arbiter_rr_priority_select #(
        .N  (N_MASTERS),
        .GW (GW)
    ) u_select (
        .req    (m_valid),
        .last   (last_q),
        .winner (winner),
        .found  (win_valid)
    );

    // Reset points 'last' at the final master so master 0 wins the first round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant   <= '0;
            last_q  <= GW'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && win_valid) begin
                grant  <= winner;
                last_q <= winner;
            end
        end
    end

    always_comb begin
        owner_valid  = 1'b0;
        owner_onehot = '0;
        s_addr       = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant == GW'(i)) begin
                owner_valid     = m_valid[i];
                owner_onehot[i] = 1'b1;
                s_addr          = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata         = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb         = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // A dropped owner request aborts the transfer without a ready pulse.
    always_comb begin
        state_d = state_q;
        s_valid = 1'b0;
        m_ready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                s_valid = owner_valid;
                if (!owner_valid) begin
                    state_d = ARB_IDLE;
                end else if (s_ready) begin
                    m_ready = owner_onehot;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign m_rdata = s_rdata;
    assign busy    = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Scoreboard bench for iob_native_rr_arbiter with three masters and a
// latency-programmable slave model; completions are checked by a monitor.
module tb_iob_native_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GW = 2;

    typedef struct {
        logic [GW-1:0] grant;
        logic [N-1:0]  ready;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  m_ready;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] s_rdata;
    logic          s_ready;
    logic [GW-1:0] grant;
    logic          busy;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic          slaveEnable;
    int            slaveLat;
    logic [DW-1:0] slaveData;
    int            waitCnt;

    iob_native_rr_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .grant   (grant),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [GW-1:0] g, input logic [N-1:0] rdy, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws, input logic [DW-1:0] rd);
        exp_t e;
        e.grant = g;
        e.ready = rdy;
        e.addr  = a;
        e.wdata = wd;
        e.wstrb = ws;
        e.rdata = rd;
        expQ.push_back(e);
    endtask

    task automatic setMaster(input int i, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = wd;
        m_wstrb[i*SW +: SW] = ws;
    endtask

    // Waits for n completions within a cycle budget, then releases all requests.
    task automatic applyStimulus(input logic [N-1:0] req, input int n, input int budget);
        int seen   = 0;
        int cycles = 0;
        m_valid = req;
        while (seen < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (m_ready !== '0) seen++;
        end
        checkOutput("completions", seen, n);
        @(posedge clk);
        #1;
        m_valid = '0;
    endtask

    // Slave model: raises s_ready in the slaveLat-th cycle that s_valid is seen.
    initial begin : slave
        s_ready = 1'b0;
        s_rdata = '0;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #3;
            s_ready = 1'b0;
            if (slaveEnable && s_valid) begin
                if (waitCnt == slaveLat - 1) begin
                    s_ready = 1'b1;
                    s_rdata = slaveData;
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_ready !== '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_m_ready", 32'(m_ready), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grant", 32'(grant), 32'(e.grant));
                    checkOutput("m_ready", 32'(m_ready), 32'(e.ready));
                    checkOutput("s_addr", s_addr, e.addr);
                    checkOutput("s_wdata", s_wdata, e.wdata);
                    checkOutput("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
                    checkOutput("m_rdata", m_rdata, e.rdata);
                end
            end
        end
    end

    initial begin : stimulus
        reset       = 1'b0;
        m_valid     = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        slaveEnable = 1'b0;
        slaveLat    = 1;
        slaveData   = '0;
        setMaster(0, 32'h0000_0040, 32'h0, 4'h0);
        setMaster(1, 32'h0000_0080, 32'h0, 4'h0);
        setMaster(2, 32'h0000_00C0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_s_valid", 32'(s_valid), 32'h0);
        checkOutput("rst_m_ready", 32'(m_ready), 32'h0);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        reset = 1'b1;

        // Single request from master 0, three-cycle slave, one arbitration cycle.
        slaveEnable = 1'b1;
        slaveLat    = 3;
        slaveData   = 32'hA5A5_0001;
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        m_valid = 3'b001;
        @(negedge clk);
        checkOutput("t1_arb_cycle_s_valid", 32'(s_valid), 32'h0);
        @(negedge clk);
        checkOutput("t1_s_valid", 32'(s_valid), 32'h1);
        checkOutput("t1_s_addr", s_addr, 32'h40);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        applyStimulus(3'b001, 1, 20);

        // Fresh reset, then two masters held: grants alternate 0,1,0,1.
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        slaveLat  = 1;
        slaveData = 32'h0000_0B0B;
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'h0000_0B0B);
        pushExp(2'd1, 3'b010, 32'h80, 32'h0, 4'h0, 32'h0000_0B0B);
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'h0000_0B0B);
        pushExp(2'd1, 3'b010, 32'h80, 32'h0, 4'h0, 32'h0000_0B0B);
        applyStimulus(3'b011, 4, 40);

        // Master 2 served, then 101: order 0,2,0,2 and master 1 never granted.
        slaveData = 32'h0000_0C0C;
        pushExp(2'd2, 3'b100, 32'hC0, 32'h0, 4'h0, 32'h0000_0C0C);
        applyStimulus(3'b100, 1, 20);
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'h0000_0C0C);
        pushExp(2'd2, 3'b100, 32'hC0, 32'h0, 4'h0, 32'h0000_0C0C);
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'h0000_0C0C);
        pushExp(2'd2, 3'b100, 32'hC0, 32'h0, 4'h0, 32'h0000_0C0C);
        applyStimulus(3'b101, 4, 40);

        // Write then read from master 1.
        slaveLat  = 2;
        slaveData = 32'h0;
        setMaster(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        pushExp(2'd1, 3'b010, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
        applyStimulus(3'b010, 1, 20);
        slaveData = 32'h1234_5678;
        setMaster(1, 32'h0000_0104, 32'h0, 4'h0);
        pushExp(2'd1, 3'b010, 32'h104, 32'h0, 4'h0, 32'h1234_5678);
        applyStimulus(3'b010, 1, 20);

        // Abort: master 0 drops its request in BUSY; master 1 is served next.
        slaveEnable = 1'b0;
        m_valid     = 3'b001;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_busy", 32'(busy), 32'h1);
        checkOutput("t5_grant", 32'(grant), 32'h0);
        checkOutput("t5_s_valid", 32'(s_valid), 32'h1);
        @(posedge clk);
        #1;
        m_valid = 3'b010;
        #1;
        checkOutput("t5_s_valid_drop", 32'(s_valid), 32'h0);
        @(negedge clk);
        checkOutput("t5_no_m_ready", 32'(m_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t5_idle_busy", 32'(busy), 32'h0);
        checkOutput("t5_idle_s_valid", 32'(s_valid), 32'h0);
        slaveEnable = 1'b1;
        slaveData   = 32'h0000_5555;
        pushExp(2'd1, 3'b010, 32'h104, 32'h0, 4'h0, 32'h0000_5555);
        applyStimulus(3'b010, 1, 20);

        // Asynchronous reset while the slave is completing a transfer.
        slaveLat = 1;
        m_valid  = 3'b001;
        @(posedge clk);
        #7;
        checkOutput("t6_busy_before", 32'(busy), 32'h1);
        checkOutput("t6_m_ready_before", 32'(m_ready), 32'h1);
        #1 reset = 1'b0;
        #1;
        checkOutput("t6_async_s_valid", 32'(s_valid), 32'h0);
        checkOutput("t6_async_m_ready", 32'(m_ready), 32'h0);
        checkOutput("t6_async_busy", 32'(busy), 32'h0);
        reset     = 1'b1;
        m_valid   = 3'b011;
        slaveData = 32'h0000_6666;
        @(negedge clk);
        checkOutput("t6_idle_s_ready_ignored", 32'(m_ready), 32'h0);
        pushExp(2'd0, 3'b001, 32'h40, 32'h0, 4'h0, 32'h0000_6666);
        applyStimulus(3'b011, 1, 20);

        repeat (3) @(posedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
